uart_tx_mmio: RTL and testbench

//  Memory-mapped UART transmitter: the device the boot prompt firmware polls and writes.
//  CPU stores bytes to TXDATA; they are buffered in a small FIFO and serialized 8N1, LSB first, on tx.

---
 rtl/uart_tx_mmio.sv | 196 +++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter behind a small TX FIFO; loads return data one cycle after the request.
// Stores to a full FIFO are dropped and set a sticky overflow flag; firmware polls STATUS.tx_ready before storing.
module uart_tx_mmio #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [3:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int RL   = CLKS_PER_BIT - 1;
  localparam logic [CNTW-1:0] DEPTH_C  = FIFO_DEPTH[CNTW-1:0];
  localparam logic [CW-1:0]   RELOAD_C = RL[CW-1:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [2:0]      r_idx;
  logic [2:0]      w_idx_nxt;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_nxt;
  logic            r_tx;
  logic            w_tx_nxt;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic            r_ovf;
  logic [31:0]     r_rdata;

  logic            w_load;
  logic            w_store;
  logic            w_push;
  logic            w_push_ok;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic            w_busy;
  logic            w_ovf_clr;
  logic [31:0]     w_status;
  logic [31:0]     w_rdata_nxt;
  logic            w_unused;

  assign w_load    = req_valid & ~req_we;
  assign w_store   = req_valid & req_we;
  assign w_full    = (r_count == DEPTH_C);
  assign w_empty   = (r_count == '0);
  assign w_push    = w_store & (req_addr == 4'h8);
  assign w_push_ok = w_push & ~w_full;
  assign w_ovf_clr = w_store & (req_addr == 4'h0) & req_wdata[2];
  assign w_busy    = (r_state != S_IDLE) | ~w_empty;
  assign w_status  = {29'b0, r_ovf, w_busy, ~w_full};
  assign w_unused  = &{1'b0, req_wdata[31:8]};

  // FIFO storage needs no reset: entries are only read while the registered count covers them.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= req_wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push & w_full) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_cnt_nxt   = RELOAD_C;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_cnt == '0) begin
          w_cnt_nxt   = RELOAD_C;
          w_idx_nxt   = 3'd0;
          w_state_nxt = S_DATA;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_DATA: begin
        if (r_cnt == '0) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_cnt_nxt   = RELOAD_C;
          if (r_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_STOP: begin
        // A waiting byte goes straight into its start bit so frames abut with no idle gap.
        if (r_cnt == '0) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = r_mem[r_rd_ptr];
            w_cnt_nxt   = RELOAD_C;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // The line is registered from the next state so it changes only on bit boundaries.
  assign w_tx_nxt = (w_state_nxt == S_DATA) ? w_shift_nxt[0] : (w_state_nxt != S_START);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  assign w_rdata_nxt = (req_addr == 4'h0) ? w_status : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= 32'd0;
    end else if (w_load) begin
      r_rdata <= w_rdata_nxt;
    end
  end

  assign rdata = r_rdata;
  assign tx    = r_tx;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Randomised bench for uart_tx_mmio: a schedule-based model predicts STATUS loads and serial frames,
// and independent monitors compare rdata and the tx line against the queued expectations.
module tb_uart_tx_mmio;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [3:0]  req_addr = 4'h0;
  logic [31:0] req_wdata = 32'd0;
  logic [31:0] rdata;
  logic        tx;

  uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rdata     (rdata),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h cycle=%0d", name, got, exp, cyc);
    end
  endtask

  // Model: each accepted byte is popped at max(visible cycle, end of previous frame).
  typedef struct {
    logic [7:0] b;
    int         st;
    int         pop;
  } sch_t;

  typedef struct {
    logic [31:0] v;
    int          due;
  } rd_t;

  sch_t sched[$];
  sch_t exp_tx_q[$];
  rd_t  rd_q[$];
  bit   m_ovf = 1'b0;
  int   last_end = -1;

  function automatic int occ(input int t);
    int n = 0;
    foreach (sched[i]) if (sched[i].st < t && sched[i].pop >= t) n++;
    return n;
  endfunction

  function automatic bit sending(input int t);
    foreach (sched[i]) if (t > sched[i].pop && t <= sched[i].pop + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    sched.delete();
    exp_tx_q.delete();
    m_ovf    = 1'b0;
    last_end = -1;
  endtask

  // Called at the start of the cycle in which the request is presented.
  task automatic bus(input bit we, input logic [3:0] a, input logic [31:0] d);
    int   n;
    int   p;
    rd_t  r;
    sch_t s;
    n = occ(cyc);
    if (!we) begin
      r.v   = (a == 4'h0) ? {29'b0, m_ovf, (n != 0) || sending(cyc), n != DEPTH} : 32'd0;
      r.due = cyc + 1;
      rd_q.push_back(r);
    end else if (a == 4'h8) begin
      if (n < DEPTH) begin
        p     = (cyc + 1 > last_end) ? cyc + 1 : last_end;
        s.b   = d[7:0];
        s.st  = cyc;
        s.pop = p;
        sched.push_back(s);
        exp_tx_q.push_back(s);
        last_end = p + FRAME;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (a == 4'h0 && d[2]) begin
      m_ovf = 1'b0;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 4'h0;
    req_wdata = 32'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // rdata monitor
  always @(negedge clk) begin
    rd_t r;
    if (!rst) begin
      chk("reset_tx", {31'b0, tx}, 32'd1);
      chk("reset_rdata", rdata, 32'd0);
    end else if (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
      r = rd_q.pop_front();
      chk("load_rdata", rdata, r.v);
    end
  end

  // tx line monitor
  bit         in_frame = 1'b0;
  bit         wave_ok;
  int         f_start;
  int         last_start = -1;
  logic [7:0] rx;
  sch_t       cur;

  always @(negedge clk) begin
    int   off;
    int   b;
    logic e;
    if (!rst) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && tx !== 1'b1) begin
        if (exp_tx_q.size() == 0) begin
          chk("tx_idle", {31'b0, tx}, 32'd1);
        end else begin
          cur = exp_tx_q.pop_front();
          chk("frame_start_cycle", cyc, cur.pop + 1);
          in_frame   = 1'b1;
          f_start    = cyc;
          last_start = cyc;
          wave_ok    = 1'b1;
          rx         = 8'd0;
        end
      end
      if (in_frame) begin
        off = cyc - f_start;
        b   = off / CPB;
        if (b == 0) e = 1'b0;
        else if (b <= 8) e = cur.b[b-1];
        else e = 1'b1;
        if (tx !== e) wave_ok = 1'b0;
        if (off % CPB == CPB / 2 && b >= 1 && b <= 8) rx[b-1] = tx;
        if (off == FRAME - 1) begin
          chk("frame_byte", {24'b0, rx}, {24'b0, cur.b});
          chk("frame_waveform", {31'b0, wave_ok}, 32'd1);
          in_frame = 1'b0;
        end
      end
    end
  end

  task automatic drain(input string name, input int bound);
    int i = 0;
    while (!(exp_tx_q.size() == 0 && !in_frame && cyc > last_end + 1) && i < bound) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk(name, {31'b0, i < bound}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n2;
    int op;
    int k;

    // Reset and post-reset state
    rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_tx", {31'b0, tx}, 32'd1);
    chk("post_reset_rdata", rdata, 32'd0);
    @(posedge clk);
    #1;
    bus(1'b0, 4'h0, 32'd0);
    bus(1'b0, 4'h4, 32'd0);
    bus(1'b0, 4'h8, 32'd0);
    idle(2);

    // Single byte with STATUS sampled mid-frame and at the frame boundary
    n2 = cyc;
    bus(1'b1, 4'h8, 32'hFFFF_FF3E);
    idle(19);
    bus(1'b0, 4'h0, 32'd0);
    idle(20);
    bus(1'b0, 4'h0, 32'd0);
    bus(1'b0, 4'h0, 32'd0);
    drain("drain_single", 200);
    chk("single_start_latency", last_start, n2 + 2);

    // Overflow: six consecutive stores, then poll STATUS every cycle
    for (int i = 0; i < 6; i++) bus(1'b1, 4'h8, 32'h30 + i);
    for (int i = 0; i < 40; i++) bus(1'b0, 4'h0, 32'd0);
    drain("drain_overflow", 400);

    // Overflow clear only on wdata[2]
    bus(1'b0, 4'h0, 32'd0);
    bus(1'b1, 4'h0, 32'h0000_0003);
    bus(1'b0, 4'h0, 32'd0);
    bus(1'b1, 4'h0, 32'h0000_0004);
    bus(1'b0, 4'h0, 32'd0);
    idle(2);

    // Randomised traffic
    for (int i = 0; i < 120; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        bus(1'b1, 4'h8, $urandom);
      end else if (op == 4) begin
        k = $urandom_range(2, 6);
        for (int j = 0; j < k; j++) bus(1'b1, 4'h8, $urandom);
      end else if (op <= 6) begin
        bus(1'b0, 4'($urandom_range(0, 15)), 32'd0);
      end else if (op == 7) begin
        bus(1'b1, 4'($urandom_range(0, 15)), $urandom);
      end else begin
        idle($urandom_range(1, 50));
      end
    end
    drain("drain_random", 2000);
    bus(1'b1, 4'h0, 32'h0000_0004);
    bus(1'b0, 4'h0, 32'd0);
    idle(2);

    // Reset while the second of three frames is in its data bits
    bus(1'b1, 4'h8, 32'hA5);
    bus(1'b1, 4'h8, 32'h00);
    bus(1'b1, 4'h8, 32'hFF);
    idle(50);
    #1;
    chk("pre_reset_tx_low", {31'b0, tx}, 32'd0);
    rst = 1'b0;
    model_reset();
    #1;
    chk("async_reset_tx", {31'b0, tx}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(100);
    bus(1'b0, 4'h0, 32'd0);
    idle(2);

    // Normal operation resumes after reset
    bus(1'b1, 4'h8, 32'h5A);
    drain("drain_after_reset", 200);
    idle(3);

    chk("tx_queue_empty", exp_tx_q.size(), 32'd0);
    chk("rd_queue_empty", rd_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
